// File: rtl/cache_set_assoc.sv
// One set of an N-way set-associative cache: tag/valid/dirty per way, true-LRU ages,
// dirty-victim writeback and line fill from the next level, one request in flight.
module cache_set_assoc #(
  parameter int unsigned WAYS   = 8,
  parameter int unsigned TAG_W  = 24,
  parameter int unsigned LINE_W = 512,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [TAG_W-1:0]      req_tag,
  input  logic [LINE_W-1:0]     req_wdata,
  input  logic [LINE_W/8-1:0]   req_wstrb,
  output logic                  resp_valid,
  output logic                  resp_hit,
  output logic [LINE_W-1:0]     resp_rdata,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [TAG_W-1:0]      wb_tag,
  output logic [LINE_W-1:0]     wb_data,
  output logic                  fill_req,
  output logic [TAG_W-1:0]      fill_tag,
  input  logic                  fill_valid,
  input  logic [LINE_W-1:0]     fill_data,
  output logic [CNT_W-1:0]      hit_count,
  output logic [CNT_W-1:0]      miss_count
);

  localparam int unsigned AGE_W  = $clog2(WAYS);
  localparam int unsigned STRB_W = LINE_W / 8;

  typedef enum logic [2:0] {StIdle, StLookup, StWriteback, StFill, StResp} state_e;

  state_e state_q, state_d;

  logic                req_write_q;
  logic [TAG_W-1:0]    req_tag_q;
  logic [LINE_W-1:0]   req_wdata_q;
  logic [STRB_W-1:0]   req_wstrb_q;

  logic [WAYS-1:0]     valid_q, dirty_q;
  logic [TAG_W-1:0]    tag_q  [WAYS];
  logic [LINE_W-1:0]   data_q [WAYS];
  logic [AGE_W-1:0]    age_q  [WAYS];
  logic [AGE_W-1:0]    victim_q;

  logic                resp_valid_q, resp_hit_q;
  logic [LINE_W-1:0]   resp_rdata_q, wb_data_q;
  logic [TAG_W-1:0]    wb_tag_q, fill_tag_q;
  logic [CNT_W-1:0]    hit_count_q, miss_count_q;

  logic                hit;
  logic [AGE_W-1:0]    hit_way, victim_way, acc_way;
  logic                victim_found;
  logic                do_access;
  logic [LINE_W-1:0]   base_line, merged_line;

  // Tag match and victim choice: lowest invalid way, else the oldest way.
  always_comb begin
    hit          = 1'b0;
    hit_way      = '0;
    victim_way   = '0;
    victim_found = 1'b0;
    for (int i = 0; i < WAYS; i++) begin
      if (valid_q[i] && (tag_q[i] == req_tag_q)) begin
        hit     = 1'b1;
        hit_way = AGE_W'(i);
      end
    end
    for (int i = 0; i < WAYS; i++) begin
      if (!victim_found && !valid_q[i]) begin
        victim_way   = AGE_W'(i);
        victim_found = 1'b1;
      end
    end
    if (!victim_found) begin
      for (int i = 0; i < WAYS; i++) begin
        if (age_q[i] == AGE_W'(WAYS - 1)) victim_way = AGE_W'(i);
      end
    end
  end

  // The access happens either on a lookup hit or on the fill beat into the victim.
  always_comb begin
    do_access = ((state_q == StLookup) && hit) || ((state_q == StFill) && fill_valid);
    acc_way   = (state_q == StFill) ? victim_q : hit_way;
    base_line = (state_q == StFill) ? fill_data : data_q[acc_way];
    for (int b = 0; b < STRB_W; b++) begin
      merged_line[8*b +: 8] = (req_write_q && req_wstrb_q[b]) ? req_wdata_q[8*b +: 8]
                                                                : base_line[8*b +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:      if (req_valid) state_d = StLookup;
      StLookup: begin
        if (hit)                                          state_d = StResp;
        else if (valid_q[victim_way] && dirty_q[victim_way]) state_d = StWriteback;
        else                                              state_d = StFill;
      end
      StWriteback: if (wb_ready) state_d = StFill;
      StFill:      if (fill_valid) state_d = StResp;
      StResp:      state_d = StIdle;
      default:     state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      req_write_q  <= 1'b0;
      req_tag_q    <= '0;
      req_wdata_q  <= '0;
      req_wstrb_q  <= '0;
      valid_q      <= '0;
      dirty_q      <= '0;
      victim_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_rdata_q <= '0;
      wb_tag_q     <= '0;
      wb_data_q    <= '0;
      fill_tag_q   <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
      for (int i = 0; i < WAYS; i++) age_q[i] <= AGE_W'(i);
    end else begin
      state_q      <= state_d;
      resp_valid_q <= do_access;
      if (state_q == StIdle && req_valid) begin
        req_write_q <= req_write;
        req_tag_q   <= req_tag;
        req_wdata_q <= req_wdata;
        req_wstrb_q <= req_wstrb;
      end
      if (state_q == StLookup) begin
        if (hit) begin
          if (hit_count_q != '1) hit_count_q <= hit_count_q + 1'b1;
        end else begin
          if (miss_count_q != '1) miss_count_q <= miss_count_q + 1'b1;
          victim_q   <= victim_way;
          wb_tag_q   <= tag_q[victim_way];
          wb_data_q  <= data_q[victim_way];
          fill_tag_q <= req_tag_q;
        end
      end
      if (state_q == StWriteback && wb_ready) begin
        valid_q[victim_q] <= 1'b0;
        dirty_q[victim_q] <= 1'b0;
      end
      if (do_access) begin
        valid_q[acc_way] <= 1'b1;
        dirty_q[acc_way] <= req_write_q | ((state_q == StLookup) & dirty_q[acc_way]);
        resp_hit_q       <= (state_q == StLookup);
        resp_rdata_q     <= merged_line;
        for (int i = 0; i < WAYS; i++) begin
          if (AGE_W'(i) == acc_way)            age_q[i] <= '0;
          else if (age_q[i] < age_q[acc_way])  age_q[i] <= age_q[i] + 1'b1;
        end
      end
    end
  end

  // Line storage is deliberately not reset; valid bits guard it.
  always_ff @(posedge clk) begin
    if (do_access) begin
      data_q[acc_way] <= merged_line;
      if (state_q == StFill) tag_q[acc_way] <= req_tag_q;
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign wb_valid   = (state_q == StWriteback);
  assign fill_req   = (state_q == StFill);
  assign resp_valid = resp_valid_q;
  assign resp_hit   = resp_hit_q;
  assign resp_rdata = resp_rdata_q;
  assign wb_tag     = wb_tag_q;
  assign wb_data    = wb_data_q;
  assign fill_tag   = fill_tag_q;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

endmodule

// File: doc/cache_set_assoc.md
# cache_set_assoc

Parametrised N-way set-associative cache set: holds WAYS lines, each with tag, valid and dirty bits, and services one read or write request at a time. Hits complete locally. Misses pick an LRU victim, write it back if dirty, request a fill from the next level, install the line, then complete the original access. It is the per-set building block that the cache top instantiates once per index, with the index decode outside this block.

## Interface

Parameters:
- WAYS, 8, associativity; power of two, 2..16
- TAG_W, 24, tag width in bits
- LINE_W, 512, line width in bits; multiple of 8
- CNT_W, 32, width of the hit and miss statistics counters

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_write  in  1  0 = read, 1 = write
- req_tag  in  TAG_W  request tag
- req_wdata  in  LINE_W  write data
- req_wstrb  in  LINE_W/8  byte enables for writes
- resp_valid  out  1  one-cycle response pulse
- resp_hit  out  1  request hit without a fill
- resp_rdata  out  LINE_W  line contents after the access
- wb_valid  out  1  dirty victim writeback request
- wb_ready  in  1  next level accepts writeback
- wb_tag  out  TAG_W  victim tag
- wb_data  out  LINE_W  victim data
- fill_req  out  1  fill request
- fill_tag  out  TAG_W  tag to fetch
- fill_valid  in  1  fill data returned
- fill_data  in  LINE_W  fill line
- hit_count  out  CNT_W  saturating hit counter
- miss_count  out  CNT_W  saturating miss counter

## Operation

- States: IDLE, LOOKUP, WRITEBACK, FILL, RESP.
- IDLE: req_ready=1. On req_valid, latch the request and go to LOOKUP.
- LOOKUP: compare the latched tag against every valid way; at most one way may match.
  - Hit: perform the access and go to RESP.
  - Miss, victim dirty: go to WRITEBACK.
  - Miss, victim clean: go to FILL.
- Victim selection: lowest-index invalid way; if all ways are valid, the way with age WAYS-1.
- WRITEBACK: hold wb_valid=1 with a stable wb_tag and wb_data until the cycle wb_ready=1. Then clear the victim's valid bit and go to FILL.
- FILL: hold fill_req=1 with fill_tag until the cycle fill_valid=1.
  - Install fill_data in the victim way: valid=1, dirty=0, tag=request tag.
  - Perform the access on the installed line, then go to RESP.
- Access rules:
  - Read returns the line.
  - Write merges req_wdata into the line under req_wstrb, sets dirty=1, and returns the merged line.
- RESP: resp_valid=1 for one cycle, then go to IDLE.
- LRU: each way has a $clog2(WAYS)-bit age. On any access to way w with age a:
  - every way with age < a increments;
  - way w's age becomes 0.
  - Ages always form a permutation of 0..WAYS-1.
- Counters: hit_count increments on a LOOKUP hit; miss_count increments on a LOOKUP miss. Both saturate at all-ones.
- wb_ready and fill_valid are ignored outside WRITEBACK and FILL respectively.

## Timing

- Reset (rst_n low, asynchronous):
  - state=IDLE; all valid and dirty bits cleared.
  - age[i]=i.
  - Counters 0.
  - req_ready=1; resp_valid, resp_hit, wb_valid, fill_req all 0.
  - resp_rdata, wb_tag, wb_data, fill_tag all 0.
  - Line data and tags are not reset.
- Hit latency:
  - Accept edge T; LOOKUP during cycle T+1.
  - resp_valid high during cycle T+2.
  - req_ready high again at T+3.
- Clean miss: fill_req is asserted from cycle T+2. The fill_valid edge F leads to resp_valid at F+1 with resp_hit=0.
- Dirty miss: wb_valid is asserted from cycle T+2. fill_req is asserted the cycle after wb_ready is sampled high.
- fill_valid arriving in the same cycle fill_req first rises is legal and accepted.
- req_valid is ignored while req_ready=0; the block never queues requests.
- Reset mid-transaction aborts immediately:
  - any outstanding writeback or fill is dropped with no partial install;
  - the dirty victim's data is lost. This is acceptable and is documented for the cache top.
- resp_* outputs are registered; resp_rdata holds its value until the next RESP.

## Test plan

- Reset, then read tag 0x000A5 → miss.
  - fill_req with fill_tag 0x000A5 appears 2 cycles after accept.
  - Return 0xDEAD… → resp_hit=0, rdata 0xDEAD…, miss_count=1.
  - Re-read → resp_hit=1 at T+2, hit_count=1.
- Write tag 0x10 with wstrb=0x...0001, wdata byte0=0x5A to a line filled with all 0xFF → resp_rdata byte0=0x5A, other bytes 0xFF.
- WAYS=8: fill tags 0..7, write tag 3, then touch 0,1,2,4,5,6,7.
  - Read tag 8 → wb_valid with wb_tag=3 and the merged data.
  - Hold wb_ready=0 for 5 cycles → wb_valid stays high and fill_req stays low.
  - Then fill completes into the former way 3.
- LRU order: fill 0..7, re-read tag 0, then miss on tag 9 → victim is tag 1 (fill_req only, no wb_valid because the line is clean).
- Assert rst_n low while in FILL → outputs return to reset values immediately.
  - A subsequent read of the pending tag misses again.
  - hit_count=0 and miss_count=0.
- Force miss_count to saturation (CNT_W=4 build, 16 misses) → the counter holds at 0xF.
